// File: rtl/add8_err_monitor.sv
// add8_err_monitor: drives every {B,A} operand pair into an external adder,
// matches the returned sums against the exact sums held in a small in-order
// FIFO, and accumulates the error metrics (MAE/MSE sums, WCE, EP count, HD).
// Optional build macro: ADD_ERR_MSE_EN builds the squarer and the err_sq_sum
// accumulator; without it err_sq_sum is tied to zero.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RUN   | issuing vectors, one per cycle while the FIFO has room
// S_DRAIN | all vectors issued, waiting for outstanding results
// S_DONE  | sweep complete, done held high until the next start
module add8_err_monitor #(
    parameter int W          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic             op_valid,
    input  logic [W:0]       res_sum,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic             proto_err,
    output logic [3*W:0]     err_sum,
    output logic [4*W+1:0]   err_sq_sum,
    output logic [W:0]       wce,
    output logic [2*W:0]     err_cnt,
    output logic [2*W+3:0]   hd_sum
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [2*W-1:0]  v;
    logic [W:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            empty;
    logic            full;
    logic            start_ok;
    logic            push;
    logic            pop;
    logic            store_push;
    logic            store_pop;
    logic            proto_hit;
    logic [W:0]      exact_now;
    logic [W:0]      exp_head;
    logic [W:0]      d;
    logic [W:0]      diff_x;
    logic [2*W+3:0]  hd;

    assign op_a      = v[W-1:0];
    assign op_b      = v[2*W-1:W];
    assign exact_now = {1'b0, op_a} + {1'b0, op_b};

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

    // A full FIFO can still take a vector when a result frees the head slot.
    assign op_valid  = (state == S_RUN) && (!full || res_valid);
    assign push      = op_valid;

    // A result arriving in the same cycle as an issue into an empty FIFO
    // (zero-latency loopback) is matched directly against the sum being issued.
    assign pop        = res_valid && (!empty || push);
    assign proto_hit  = res_valid && empty && !push;
    assign store_push = push && !(empty && pop);
    assign store_pop  = pop && !empty;
    assign exp_head   = empty ? exact_now : fifo_mem[rd_ptr];

    // Error magnitude and Hamming distance of the returned sum.
    always_comb begin
        d      = (res_sum >= exp_head) ? (res_sum - exp_head) : (exp_head - res_sum);
        diff_x = res_sum ^ exp_head;
        hd     = '0;
        for (int i = 0; i <= W; i++) begin
            hd = hd + (2*W+4)'(diff_x[i]);
        end
    end

    // Expected-sum storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (store_push) begin
            fifo_mem[wr_ptr] <= exact_now;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store_push) wr_ptr <= wr_ptr + AW'(1);
            if (store_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({store_push, store_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sweep sequencing: vector counter, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            v     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        v     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        if (v == '1) state <= S_DRAIN;
                        else         v     <= v + (2*W)'(1);
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Error accumulators: cleared by an accepted start, updated on every match.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_sum <= '0;
            wce     <= '0;
            err_cnt <= '0;
            hd_sum  <= '0;
        end else if (pop) begin
            err_sum <= err_sum + (3*W+1)'(d);
            wce     <= (d > wce) ? d : wce;
            err_cnt <= err_cnt + (2*W+1)'(d != '0);
            hd_sum  <= hd_sum + hd;
        end
    end

    // Sticky protocol error; a new violation wins over a clearing start.
    always_ff @(posedge clk) begin
        if (rst)            proto_err <= 1'b0;
        else if (proto_hit) proto_err <= 1'b1;
        else if (start_ok)  proto_err <= 1'b0;
    end

`ifdef ADD_ERR_MSE_EN
    logic [2*W+1:0] sq;
    logic [4*W+1:0] sq_acc;

    assign sq = (2*W+2)'(d) * (2*W+2)'(d);

    // Squared-error accumulator (MSE numerator).
    always_ff @(posedge clk) begin
        if (rst || start_ok) sq_acc <= '0;
        else if (pop)        sq_acc <= sq_acc + (4*W+2)'(sq);
    end

    assign err_sq_sum = sq_acc;
`else
    assign err_sq_sum = '0;
`endif

endmodule
